// File: rtl/icache_pkg.sv
// Shared types and widths for the instruction cache refill path.
package icache_pkg;

   // Width of one replacement beat delivered to the cache sets.
   localparam int ICACHE_BEAT_W = 64;

   // Width of one memory response word.
   localparam int MEM_WORD_W    = 32;

   // Refill controller states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      COLLECT = 3'd2,
      STREAM  = 3'd3,
      SETTLE  = 3'd4
   } refill_state_t;

endpackage : icache_pkg

// File: rtl/instr_refill_line_buf.sv
// Line buffer for one cache block: (B/8) x 64-bit distributed RAM.
// The write side takes one 32-bit memory word at a time. The word index LSB
// selects the half of the beat, so beat k holds {word[2k+1], word[2k]}.
// The read side is a registered 64-bit port indexed by beat number.
module instr_refill_line_buf
   import icache_pkg::*;
#(
   parameter int B = 64,
   localparam int WIDX_W = $clog2(B / 4),
   localparam int BIDX_W = $clog2(B / 8)
)
(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDX_W-1:0]        i_wr_idx,
   input  logic [MEM_WORD_W-1:0]    i_wr_data,
   input  logic                     i_rd_en,
   input  logic [BIDX_W-1:0]        i_rd_idx,
   output logic [ICACHE_BEAT_W-1:0] o_rd_data
);

   logic [ICACHE_BEAT_W-1:0] r_mem [B/8];
   logic [ICACHE_BEAT_W-1:0] r_rd_data;
   logic [BIDX_W-1:0]        w_wr_beat;

   assign w_wr_beat = i_wr_idx[WIDX_W-1:1];

   // Write one 32-bit word into the upper or lower half of its beat.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         if (i_wr_idx[0]) begin
            r_mem[w_wr_beat][ICACHE_BEAT_W-1:MEM_WORD_W] <= i_wr_data;
         end else begin
            r_mem[w_wr_beat][MEM_WORD_W-1:0] <= i_wr_data;
         end
      end
   end

   // Registered read port; cleared by reset so the replacement beat reads 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_idx];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule : instr_refill_line_buf

// File: rtl/instr_cache_refill.sv
// Instruction cache refill controller.
// On a fetch miss it issues one block-aligned read, collects B/4 response
// words into the line buffer, then streams B/8 contiguous 64-bit beats with
// rep_enable_o held high for the whole stream (the cache set's beat counter
// clears whenever its enable drops). One SETTLE cycle with the enable low
// follows before returning to IDLE.
// Optional feature macro: ICACHE_REFILL_PERF_EN builds the refill and stall
// cycle counters; without it both counter outputs are tied to 0.
module instr_cache_refill
   import icache_pkg::*;
#(
   parameter int B      = 64,
   parameter int ADDR_W = 32
)
(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     miss_i,
   input  logic [ADDR_W-1:0]        miss_addr_i,
   output logic                     rep_enable_o,
   output logic [ICACHE_BEAT_W-1:0] rep_word_o,
   output logic                     stall_o,
   output logic                     mem_req_o,
   output logic [ADDR_W-1:0]        mem_addr_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [MEM_WORD_W-1:0]    mem_rdata_i,
   output logic [31:0]              refill_cnt_o,
   output logic [31:0]              stall_cyc_o
);

   localparam int OFF_W  = $clog2(B);
   localparam int WCNT_W = $clog2(B / 4);
   localparam int SCNT_W = $clog2(B / 8);

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(B / 4 - 1);

   refill_state_t       r_state;
   logic                r_req;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_rep_en;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [SCNT_W-1:0]   r_scnt;

   logic                w_wr_en;
   logic                w_rd_en;
   logic                w_stream_done;
   logic                w_unused;

   // The offset bits of the fetch address never reach the memory port.
   assign w_unused = ^miss_addr_i[OFF_W-1:0];

   // The read port is registered, so a beat appears one cycle after it is
   // addressed. Once the enable is high and the beat index has wrapped back
   // to 0, the last beat is on the output and the stream is complete.
   assign w_stream_done = r_rep_en & (r_scnt == '0);

   assign w_wr_en = (r_state == COLLECT) & mem_rvalid_i;
   assign w_rd_en = (r_state == STREAM) & ~w_stream_done;

   // Refill sequencing with registered request, address and enable outputs.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state  <= IDLE;
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_rep_en <= 1'b0;
         r_wcnt   <= '0;
         r_scnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (miss_i) begin
                  r_addr  <= {miss_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  r_req   <= 1'b1;
                  r_wcnt  <= '0;
                  r_scnt  <= '0;
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  r_req   <= 1'b0;
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               if (mem_rvalid_i) begin
                  r_wcnt <= r_wcnt + 1'b1;
                  if (r_wcnt == WCNT_LAST) begin
                     r_state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (w_stream_done) begin
                  r_rep_en <= 1'b0;
                  r_state  <= SETTLE;
               end else begin
                  r_rep_en <= 1'b1;
                  r_scnt   <= r_scnt + 1'b1;
               end
            end
            SETTLE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   instr_refill_line_buf #(
      .B (B)
   ) u_line_buf (
      .i_clk     (clk_i),
      .i_rst_n   (reset_i),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (r_wcnt),
      .i_wr_data (mem_rdata_i),
      .i_rd_en   (w_rd_en),
      .i_rd_idx  (r_scnt),
      .o_rd_data (rep_word_o)
   );

   assign rep_enable_o = r_rep_en;
   assign mem_req_o    = r_req;
   assign mem_addr_o   = r_addr;
   assign stall_o      = (r_state != IDLE) | miss_i;

`ifdef ICACHE_REFILL_PERF_EN
   logic [31:0] r_refill_cnt;
   logic [31:0] r_stall_cyc;
   logic        w_refill_done;

   assign w_refill_done = (r_state == STREAM) & w_stream_done;

   // Free-running wrap-around counters of completed refills and stall cycles.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_refill_cnt <= '0;
         r_stall_cyc  <= '0;
      end else begin
         if (w_refill_done) begin
            r_refill_cnt <= r_refill_cnt + 32'd1;
         end
         if (stall_o) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
         end
      end
   end

   assign refill_cnt_o = r_refill_cnt;
   assign stall_cyc_o  = r_stall_cyc;
`else
   assign refill_cnt_o = '0;
   assign stall_cyc_o  = '0;
`endif

endmodule : instr_cache_refill

// File: tb/tb_instr_cache_refill.sv
// Bench for instr_cache_refill: a memory responder drives the request and
// response handshake, expected beats are queued as words are supplied and
// popped as the stream appears on the replacement port.
`timescale 1ns/1ps
module tb_instr_cache_refill;

   localparam int B      = 64;
   localparam int ADDR_W = 32;
   localparam int NW     = B / 4;
   localparam int NB     = B / 8;

   logic              clk_i        = 1'b0;
   logic              reset_i      = 1'b0;
   logic              miss_i       = 1'b0;
   logic [ADDR_W-1:0] miss_addr_i  = '0;
   logic              rep_enable_o;
   logic [63:0]       rep_word_o;
   logic              stall_o;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_gnt_i    = 1'b0;
   logic              mem_rvalid_i = 1'b0;
   logic [31:0]       mem_rdata_i  = '0;
   logic [31:0]       refill_cnt_o;
   logic [31:0]       stall_cyc_o;

   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_meas = 0;
   int          stall_base = 0;
   logic [63:0] sb_q [$];

   always #5 clk_i = ~clk_i;

   instr_cache_refill #(
      .B      (B),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .miss_i       (miss_i),
      .miss_addr_i  (miss_addr_i),
      .rep_enable_o (rep_enable_o),
      .rep_word_o   (rep_word_o),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .refill_cnt_o (refill_cnt_o),
      .stall_cyc_o  (stall_cyc_o)
   );

   // Count observed stall cycles while out of reset.
   always @(negedge clk_i) begin
      if (reset_i && stall_o) stall_meas <= stall_meas + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Follow the beat stream through SETTLE into the first IDLE cycle.
   task automatic collect_stream();
      int          n;
      int          beats;
      logic [63:0] exp;
      n = 0;
      while (!rep_enable_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      check_val("stream_lat", n, 1);
      beats = 0;
      while (rep_enable_o && beats < NB + 4) begin
         exp = 64'hBADB_ADBA_DBAD_BADB;
         if (sb_q.size() > 0) exp = sb_q.pop_front();
         check_val("beat", rep_word_o, exp);
         check_val("no_req_stream", mem_req_o, 0);
         beats++;
         @(negedge clk_i);
      end
      check_val("beat_count", beats, NB);
      check_val("settle_rep_low", rep_enable_o, 0);
      check_val("settle_stall", stall_o, 1);
      check_val("settle_req", mem_req_o, 0);
      @(negedge clk_i);
      check_val("idle_rep_low", rep_enable_o, 0);
      check_val("idle_req", mem_req_o, 0);
      check_val("idle_stall", stall_o, miss_i);
   endtask

   // One complete refill: miss, request/grant, response words, stream.
   task automatic refill(input logic [ADDR_W-1:0] addr, input int gnt_dly, input int max_gap,
                         input bit spurious, input logic [31:0] seed, input bit hold_miss);
      int                n;
      logic [31:0]       d;
      logic [31:0]       prev;
      logic [ADDR_W-1:0] exp_addr;
      exp_addr    = addr & ~ADDR_W'(B - 1);
      prev        = '0;
      miss_i      = 1'b1;
      miss_addr_i = addr;
      n = 0;
      @(negedge clk_i);
      while (!mem_req_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check_val("req_lat", n, 0);
      check_val("req_addr", mem_addr_o, exp_addr);
      if (!hold_miss) miss_i = 1'b0;
      for (int i = 0; i < gnt_dly; i++) begin
         mem_rvalid_i = spurious;
         mem_rdata_i  = 32'hDEAD_BEEF;
         @(negedge clk_i);
         check_val("req_hold", mem_req_o, 1);
         check_val("addr_hold", mem_addr_o, exp_addr);
      end
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      check_val("req_drop", mem_req_o, 0);
      for (int w = 0; w < NW; w++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk_i);
         d            = seed + 32'(w);
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = d;
         if (w % 2 == 1) sb_q.push_back({d, prev});
         prev = d;
         @(negedge clk_i);
         mem_rvalid_i = 1'b0;
      end
      collect_stream();
   endtask

   initial begin
      // Reset state
      @(negedge clk_i);
      check_val("rst_rep_en", rep_enable_o, 0);
      check_val("rst_rep_word", rep_word_o, 0);
      check_val("rst_req", mem_req_o, 0);
      check_val("rst_addr", mem_addr_o, 0);
      check_val("rst_stall", stall_o, 0);
      check_val("rst_refill_cnt", refill_cnt_o, 0);
      check_val("rst_stall_cyc", stall_cyc_o, 0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);

      // Basic refill: words 0..15
      refill(32'h0000_1234, 0, 0, 1'b0, 32'h0, 1'b0);
      // Delayed grant
      refill(32'h0000_ABCD, 5, 0, 1'b0, 32'h1000_0000, 1'b0);
      // Gapped responses with a spurious response word during REQ
      refill(32'h0004_0010, 2, 3, 1'b1, 32'h2000_0000, 1'b0);
      // Back-to-back: miss held through the first refill
      refill(32'h0000_5000, 0, 1, 1'b0, 32'h3000_0000, 1'b1);
      refill(32'h0000_6040, 0, 0, 1'b0, 32'h4000_0000, 1'b0);

      // Reset after 6 of 16 words
      miss_i      = 1'b1;
      miss_addr_i = 32'h0000_8044;
      @(negedge clk_i);
      check_val("mid_req", mem_req_o, 1);
      miss_i    = 1'b0;
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      mem_gnt_i = 1'b0;
      for (int w = 0; w < 6; w++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = 32'h0000_00A0 + 32'(w);
         @(negedge clk_i);
      end
      mem_rvalid_i = 1'b0;
      reset_i = 1'b0;
      #1;
      check_val("mid_rst_rep_en", rep_enable_o, 0);
      check_val("mid_rst_rep_word", rep_word_o, 0);
      check_val("mid_rst_req", mem_req_o, 0);
      check_val("mid_rst_addr", mem_addr_o, 0);
      check_val("mid_rst_stall", stall_o, 0);
      check_val("mid_rst_refill_cnt", refill_cnt_o, 0);
      check_val("mid_rst_stall_cyc", stall_cyc_o, 0);
      sb_q.delete();
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i    = 1'b1;
      stall_base = stall_meas;

      // Two fresh refills after reset, then the counters
      refill(32'h0000_9000, 0, 0, 1'b0, 32'h0000_0100, 1'b0);
      refill(32'h0001_2378, 0, 0, 1'b0, 32'h5500_0000, 1'b0);
      @(negedge clk_i);
`ifdef ICACHE_REFILL_PERF_EN
      check_val("perf_refill_cnt", refill_cnt_o, 2);
      check_val("perf_stall_meas", stall_cyc_o, 32'(stall_meas - stall_base));
      check_val("perf_stall_exact", stall_cyc_o, 2 * (1 + 1 + NW + NB + 1 + 1));
`else
      check_val("perf_off_refill", refill_cnt_o, 0);
      check_val("perf_off_stall", stall_cyc_o, 0);
`endif
      check_val("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_instr_cache_refill
